// File: rtl/perm_addr_pipe.sv
// perm_addr_pipe: two-stage pipelined address transform for a butterfly
// permutation network of SLICES = 2**LOG2SLICES lanes.
// Each lane address is XORed with, or rotate-added to, a configured offset.
// The block produces the per-stage switch selects, the transformed
// destinations and a flag that marks beats whose destinations collide.
//
// Handshake (both ends): a beat moves on a rising clk edge where
// valid & ready are both high. The producer holds valid and data until that
// edge. i_ready is derived only from o_ready and the internal valid bits,
// never from i_valid. While o_valid & !o_ready, every output holds.
//
// Stage A holds the accepted lane addresses and the config they were accepted
// with, and forms the transformed destinations. Stage B registers the
// destinations, the switch selects and the conflict flag.
module perm_addr_pipe #(
  parameter int LOG2SLICES = 3,
  parameter int SLICES     = 2**LOG2SLICES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SLICES*LOG2SLICES-1:0] i_addr,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic                         cfg_we,
  input  logic [LOG2SLICES-1:0]        cfg_wdata,
  input  logic                         cfg_wmode,
  output logic [LOG2SLICES*SLICES-1:0] o_sel,
  output logic [SLICES*LOG2SLICES-1:0] o_dest,
  output logic                         o_err,
  output logic                         o_valid,
  input  logic                         o_ready
);

  localparam int L  = LOG2SLICES;
  localparam int AW = SLICES * LOG2SLICES;

  // Shadow config, written at any time
  logic [L-1:0]  r_shadow_cfg;
  logic          r_shadow_mode;

  // Stage A: beat contents plus the active config captured with it
  logic          r_va;
  logic [AW-1:0] r_a_addr;
  logic [L-1:0]  r_act_cfg;
  logic          r_act_mode;

  // Stage B: output registers
  logic          r_vb;
  logic [AW-1:0] r_b_dest;
  logic [AW-1:0] r_b_sel;
  logic          r_b_err;

  logic          w_b_adv;
  logic          w_a_adv;
  logic          w_accept;
  logic [L-1:0]  w_cfg_next;
  logic          w_mode_next;
  logic [AW-1:0] w_a_dest;
  logic [AW-1:0] w_sel;
  logic          w_err;

  // Stage advance: a stage moves when empty or when the next stage moves
  assign w_b_adv  = !r_vb | o_ready;
  assign w_a_adv  = !r_va | w_b_adv;
  assign i_ready  = w_a_adv;
  assign w_accept = i_valid & w_a_adv;

  // A write coincident with an accept must reach that same beat
  assign w_cfg_next  = cfg_we ? cfg_wdata : r_shadow_cfg;
  assign w_mode_next = cfg_we ? cfg_wmode : r_shadow_mode;

  // Shadow config register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow_cfg  <= '0;
      r_shadow_mode <= 1'b0;
    end else if (cfg_we) begin
      r_shadow_cfg  <= cfg_wdata;
      r_shadow_mode <= cfg_wmode;
    end
  end

  // Stage A: capture the beat and copy shadow config to active on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_va       <= 1'b0;
      r_a_addr   <= '0;
      r_act_cfg  <= '0;
      r_act_mode <= 1'b0;
    end else if (w_a_adv) begin
      r_va <= w_accept;
      if (w_accept) begin
        r_a_addr   <= i_addr;
        r_act_cfg  <= w_cfg_next;
        r_act_mode <= w_mode_next;
      end
    end
  end

  // Per-lane transform: XOR, or add with the carry out of L bits dropped
  always_comb begin
    logic [L-1:0] lane_a;
    w_a_dest = '0;
    lane_a   = '0;
    for (int k = 0; k < SLICES; k++) begin
      lane_a = r_a_addr[k*L +: L];
      if (r_act_mode) w_a_dest[k*L +: L] = lane_a + r_act_cfg;
      else            w_a_dest[k*L +: L] = lane_a ^ r_act_cfg;
    end
  end

  // Switch selects (stage 0 uses the MSB) and pairwise duplicate detection
  always_comb begin
    w_sel = '0;
    w_err = 1'b0;
    for (int s = 0; s < L; s++) begin
      for (int k = 0; k < SLICES; k++) begin
        w_sel[s*SLICES + k] = w_a_dest[k*L + (L-1-s)];
      end
    end
    for (int j = 0; j < SLICES; j++) begin
      for (int k = j + 1; k < SLICES; k++) begin
        if (w_a_dest[j*L +: L] == w_a_dest[k*L +: L]) w_err = 1'b1;
      end
    end
  end

  // Stage B: load when free; hold everything while downstream stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vb     <= 1'b0;
      r_b_dest <= '0;
      r_b_sel  <= '0;
      r_b_err  <= 1'b0;
    end else if (w_b_adv) begin
      r_vb <= r_va;
      if (r_va) begin
        r_b_dest <= w_a_dest;
        r_b_sel  <= w_sel;
        r_b_err  <= w_err;
      end
    end
  end

  assign o_valid = r_vb;
  assign o_dest  = r_b_dest;
  assign o_sel   = r_b_sel;
  assign o_err   = r_b_err;

endmodule

// File: tb/tb_perm_addr_pipe.sv
// tb_perm_addr_pipe: directed bench for perm_addr_pipe with LOG2SLICES=3.
// Lane addresses are written as 8-digit octal literals: the rightmost digit
// is lane 0, the leftmost is lane 7.
module tb_perm_addr_pipe;

  localparam int L  = 3;
  localparam int S  = 8;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] i_addr;
  logic          i_valid;
  logic          i_ready;
  logic          cfg_we;
  logic [L-1:0]  cfg_wdata;
  logic          cfg_wmode;
  logic [AW-1:0] o_sel;
  logic [AW-1:0] o_dest;
  logic          o_err;
  logic          o_valid;
  logic          o_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entry: {err, sel, dest}
  logic [48:0] exp_q[$];
  logic [48:0] mon_ent;

  perm_addr_pipe #(.LOG2SLICES(L)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_addr   (i_addr),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .cfg_we   (cfg_we),
    .cfg_wdata(cfg_wdata),
    .cfg_wmode(cfg_wmode),
    .o_sel    (o_sel),
    .o_dest   (o_dest),
    .o_err    (o_err),
    .o_valid  (o_valid),
    .o_ready  (o_ready)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Switch selects implied by a destination vector: stage s, lane k = dest[k] bit (L-1-s)
  function automatic logic [AW-1:0] sel_of(input logic [AW-1:0] d);
    logic [AW-1:0] r;
    r = '0;
    for (int s = 0; s < L; s++)
      for (int k = 0; k < S; k++)
        r[s*S + k] = d[k*L + (L-1-s)];
    return r;
  endfunction

  // ---------------- scoreboard monitor ----------------
  // Every cycle with o_valid, the head of the queue must be on the outputs;
  // it is retired only when the handshake completes.
  always @(negedge clk) begin
    if (!reset && o_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_beat", {63'd0, o_valid}, 64'd0);
      end else begin
        mon_ent = exp_q[0];
        check_eq("sb_dest", o_dest, mon_ent[23:0]);
        check_eq("sb_sel",  o_sel,  mon_ent[47:24]);
        check_eq("sb_err",  o_err,  mon_ent[48]);
        if (o_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic set_cfg(input logic [L-1:0] v, input logic m);
    cfg_we    = 1'b1;
    cfg_wdata = v;
    cfg_wmode = m;
    @(posedge clk); #1;
    cfg_we    = 1'b0;
  endtask

  task automatic send_beat(input logic [AW-1:0] addr, input logic [AW-1:0] exp_dest,
                           input logic exp_err, input logic we, input logic [L-1:0] wd,
                           input logic wm, output int waits);
    bit timed_out;
    i_addr    = addr;
    i_valid   = 1'b1;
    cfg_we    = we;
    cfg_wdata = wd;
    cfg_wmode = wm;
    waits     = 0;
    timed_out = 1'b0;
    forever begin
      @(negedge clk);
      if (i_ready) break;
      waits++;
      if (waits >= 50) begin
        timed_out = 1'b1;
        break;
      end
    end
    if (timed_out) begin
      check_eq("accept_timeout", {63'd0, i_ready}, 64'd1);
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      exp_q.push_back({exp_err, sel_of(exp_dest), exp_dest});
    end
    i_valid = 1'b0;
    cfg_we  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
    @(posedge clk); @(negedge clk);
    check_eq({tag, "_idle"}, {63'd0, o_valid}, 64'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    reset     = 1'b1;
    i_addr    = '0;
    i_valid   = 1'b0;
    cfg_we    = 1'b0;
    cfg_wdata = '0;
    cfg_wmode = 1'b0;
    o_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_o_valid", {63'd0, o_valid}, 64'd0);
    check_eq("rst_o_err",   {63'd0, o_err},   64'd0);
    check_eq("rst_o_sel",   o_sel,   64'd0);
    check_eq("rst_o_dest",  o_dest,  64'd0);
    check_eq("rst_i_ready", {63'd0, i_ready}, 64'd1);
    @(posedge clk); #1;

    // XOR cfg=5, identity lanes; 2-cycle latency
    set_cfg(3'd5, 1'b0);
    send_beat(24'o76543210, 24'o23016745, 1'b0, 1'b0, 3'd0, 1'b0, w);
    @(negedge clk);
    check_eq("lat_cycle1_valid", {63'd0, o_valid}, 64'd0);
    @(negedge clk);
    check_eq("lat_cycle2_valid", {63'd0, o_valid}, 64'd1);
    check_eq("xor5_dest", o_dest, 24'o23016745);
    check_eq("xor5_sel",  o_sel,  24'h55CC0F);
    check_eq("xor5_err",  {63'd0, o_err}, 64'd0);
    @(posedge clk); #1;
    wait_drain("drain_xor5");

    // Rotate cfg=1, identity lanes: lane 7 wraps to 0
    set_cfg(3'd1, 1'b1);
    send_beat(24'o76543210, 24'o07654321, 1'b0, 1'b0, 3'd0, 1'b0, w);
    @(negedge clk); @(negedge clk);
    check_eq("rot1_dest", o_dest, 24'o07654321);
    check_eq("rot1_sel0", o_sel[7:0], 8'b01111000);
    check_eq("rot1_sel",  o_sel, 24'h556678);
    check_eq("rot1_err",  {63'd0, o_err}, 64'd0);
    @(posedge clk); #1;
    wait_drain("drain_rot1");

    // All-zero lanes with cfg=3 in both modes: conflict, still delivered
    set_cfg(3'd3, 1'b0);
    send_beat(24'o00000000, 24'o33333333, 1'b1, 1'b0, 3'd0, 1'b0, w);
    @(negedge clk); @(negedge clk);
    check_eq("zero_xor_valid", {63'd0, o_valid}, 64'd1);
    check_eq("zero_xor_err",   {63'd0, o_err},   64'd1);
    check_eq("zero_xor_sel",   o_sel, 24'hFFFF00);
    @(posedge clk); #1;
    set_cfg(3'd3, 1'b1);
    send_beat(24'o00000000, 24'o33333333, 1'b1, 1'b0, 3'd0, 1'b0, w);
    @(negedge clk); @(negedge clk);
    check_eq("zero_rot_valid", {63'd0, o_valid}, 64'd1);
    check_eq("zero_rot_err",   {63'd0, o_err},   64'd1);
    check_eq("zero_rot_dest",  o_dest, 24'o33333333);
    @(posedge clk); #1;
    wait_drain("drain_zero");

    // Stream of 6 back-to-back beats, rotate cfg=1, o_ready high
    set_cfg(3'd1, 1'b1);
    send_beat(24'o76543210, 24'o07654321, 1'b0, 1'b0, 3'd0, 1'b0, w); check_eq("stream_wait0", w, 0);
    send_beat(24'o00000000, 24'o11111111, 1'b1, 1'b0, 3'd0, 1'b0, w); check_eq("stream_wait1", w, 0);
    send_beat(24'o01234567, 24'o12345670, 1'b0, 1'b0, 3'd0, 1'b0, w); check_eq("stream_wait2", w, 0);
    send_beat(24'o70000007, 24'o01111110, 1'b1, 1'b0, 3'd0, 1'b0, w); check_eq("stream_wait3", w, 0);
    send_beat(24'o35172460, 24'o46203571, 1'b0, 1'b0, 3'd0, 1'b0, w); check_eq("stream_wait4", w, 0);
    send_beat(24'o66666665, 24'o77777776, 1'b1, 1'b0, 3'd0, 1'b0, w); check_eq("stream_wait5", w, 0);
    wait_drain("drain_stream");

    // Backpressure: two beats buffer, third is refused until release
    o_ready = 1'b0;
    send_beat(24'o76543210, 24'o07654321, 1'b0, 1'b0, 3'd0, 1'b0, w); check_eq("stall_wait_b1", w, 0);
    send_beat(24'o01234567, 24'o12345670, 1'b0, 1'b0, 3'd0, 1'b0, w); check_eq("stall_wait_b2", w, 0);
    i_addr  = 24'o35172460;
    i_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("stall_i_ready", {63'd0, i_ready}, 64'd0);
      check_eq("stall_o_valid", {63'd0, o_valid}, 64'd1);
    end
    @(posedge clk); #1;
    o_ready = 1'b1;
    send_beat(24'o35172460, 24'o46203571, 1'b0, 1'b0, 3'd0, 1'b0, w); check_eq("release_wait", w, 0);
    wait_drain("drain_stall");

    // Config write coincident with an accept, mid-stream
    set_cfg(3'd5, 1'b0);
    send_beat(24'o76543210, 24'o23016745, 1'b0, 1'b0, 3'd0, 1'b0, w);
    send_beat(24'o76543210, 24'o54761032, 1'b0, 1'b1, 3'd2, 1'b0, w);
    send_beat(24'o00000000, 24'o22222222, 1'b1, 1'b0, 3'd0, 1'b0, w);
    wait_drain("drain_cfgmid");

    // Reset with two beats in flight
    set_cfg(3'd3, 1'b1);
    o_ready = 1'b0;
    send_beat(24'o00000000, 24'o33333333, 1'b1, 1'b0, 3'd0, 1'b0, w);
    send_beat(24'o76543210, 24'o21076543, 1'b0, 1'b0, 3'd0, 1'b0, w);
    @(negedge clk);
    check_eq("pre_rst_i_ready", {63'd0, i_ready}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("inflight_rst_o_valid", {63'd0, o_valid}, 64'd0);
    check_eq("inflight_rst_i_ready", {63'd0, i_ready}, 64'd1);
    check_eq("inflight_rst_o_dest",  o_dest, 64'd0);
    @(posedge clk); #1;
    o_ready = 1'b1;
    send_beat(24'o01234567, 24'o01234567, 1'b0, 1'b0, 3'd0, 1'b0, w);
    @(negedge clk); @(negedge clk);
    check_eq("post_rst_cfg0_dest", o_dest, 24'o01234567);
    @(posedge clk); #1;
    wait_drain("drain_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/perm_addr_pipe.md
Name: perm_addr_pipe

Overview:
- Pipelined, parametrised successor to the combinational permutation-address slice logic.
- Accepts one beat of per-lane destination addresses for a SLICES = 2^LOG2SLICES lane butterfly permutation network.
- Applies a configurable address transform, XOR or rotate, and emits registered per-stage switch-select bits, transformed destinations and a non-permutation (conflict) flag.
- Sits between the address generator and the permutation datapath; uses a valid/ready handshake with backpressure.

Parameters:
LOG2SLICES, 3, log2 of lane count; also address width and number of network stages (legal 1..5)
SLICES, 2**LOG2SLICES, derived lane count; never overridden

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
i_addr  input  SLICES*LOG2SLICES  lane k address at [k*LOG2SLICES +: LOG2SLICES]
i_valid  input  1  input beat valid
i_ready  output  1  input beat accepted when i_valid & i_ready
cfg_we  input  1  write strobe for shadow config
cfg_wdata  input  LOG2SLICES  shadow config value
cfg_wmode  input  1  shadow mode: 0 = XOR, 1 = rotate-add
o_sel  output  LOG2SLICES*SLICES  stage s, lane k select at [s*SLICES + k]
o_dest  output  SLICES*LOG2SLICES  transformed destination per lane, same packing as i_addr
o_err  output  1  beat's destinations are not a permutation (a duplicate exists)
o_valid  output  1  output beat valid
o_ready  input  1  downstream accepts when o_valid & o_ready

Behaviour:
- Reset, synchronous on clk while reset is high:
  - o_valid=0, o_err=0, o_sel=0, o_dest=0.
  - Both pipeline valid bits cleared.
  - Shadow and active cfg = 0; mode = XOR.
  - A beat in flight is discarded.
- Config:
  - cfg_we writes the shadow registers.
  - Shadow is copied to the active registers only on the cycle a beat is accepted, and that beat uses the new value.
  - cfg_we coincident with an accept: the accepted beat uses the new (written) value.
- Pipeline: two register stages; latency 2 cycles from accept to o_valid with no stall.
  - Stage A registers dest[k]:
    - mode 0: dest[k] = addr[k] ^ cfg.
    - mode 1: dest[k] = (addr[k] + cfg) mod SLICES; the carry out of LOG2SLICES bits is dropped.
  - Stage B registers:
    - o_dest.
    - o_sel[s*SLICES+k] = dest[k][LOG2SLICES-1-s], so stage 0 takes the MSB.
    - o_err = OR over all pairs j<k of (dest[j]==dest[k]).
- Handshake:
  - Each stage advances when it is empty or the stage after it advances.
  - i_ready = !vA | (!vB | o_ready). This gives full throughput of 1 beat/cycle with o_ready held high.
  - While o_valid & !o_ready, o_sel, o_dest and o_err hold stable and o_valid stays 1.
  - i_ready is combinational from o_ready and the valid bits, never from i_valid.
- o_err is informational: the beat is still delivered and the pipeline does not stall.
- Output data is don't-care when o_valid=0, but must not change while a held beat waits.

Test Plan:
- LOG2SLICES=3, cfg=5, mode XOR, i_addr lanes 0..7 = 0..7:
  - after 2 cycles o_valid=1, dest = 5,4,7,6,1,0,3,2.
  - o_sel stage0 = 8'b00001111, stage1 = 8'b11001100, stage2 = 8'b01010101.
  - o_err=0.
- Mode rotate, cfg=1, identity addresses:
  - dest lanes = 1,2,3,4,5,6,7,0 (lane 7 wraps to 0).
  - o_err=0; stage0 sel = 8'b01111000.
- All-zero addresses with cfg=3 in either mode: every dest=3, o_err=1, o_valid still asserted.
- Stream of 6 beats with o_ready=1:
  - one output per cycle in order; i_ready never drops.
  - then hold o_ready=0 for 4 cycles: i_ready drops after 2 beats are buffered, outputs stay frozen, no beat is lost or duplicated on release.
- cfg_we with cfg_wdata=2 mid-stream, issued in the same cycle as an accept: that beat and later beats use 2; earlier beats keep the old cfg.
- Assert reset with 2 beats in flight: next cycle o_valid=0, i_ready=1, active cfg=0; a following beat uses cfg 0.
